bike_bgf_iter_ctrl: RTL and testbench
=====================================

Name: bike_bgf_iter_ctrl

Overview:
Sequencing controller for the BIKE BGF decoder. It steps the datapath through syndrome-weight, threshold and column-update passes. Iteration 0 runs three passes: BFITER, then BLACK mask, then GRAY mask. Later iterations run BFITER only. It stops early when the syndrome is zero and reports success or failure after NB_ITER iterations.

Parameters:
NB_ITER, 5, total decoder iterations (>=1)
NUM_COLS, 48, column chunks swept per pass (>=2)
COL_W, 6, width of col_addr, must satisfy 2**COL_W >= NUM_COLS
ITER_W, 3, width of iter_out, must satisfy 2**ITER_W > NB_ITER

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  start decoding (single-cycle pulse); ignored while busy
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of decoding
success  out  1  syndrome reached zero; valid with done, held until next start
sw_start  out  1  one-cycle pulse to the syndrome Hamming-weight unit
sw_done  in  1  weight result ready (pulse)
sw_zero  in  1  syndrome weight == 0; sampled when sw_done is high
th_start  out  1  one-cycle pulse to the threshold unit
th_done  in  1  threshold ready (pulse)
col_valid  out  1  column-update request valid
col_ready  in  1  column-update unit accepts the request
col_addr  out  COL_W  column chunk index
mode  out  2  pass type: 0 BFITER, 1 BLACK, 2 GRAY; stable for the whole pass
iter_out  out  ITER_W  current iteration index

Behaviour:
- Reset: resetn is synchronous and active-low; clock is clk. Reset forces state IDLE. busy, done, success, sw_start, th_start and col_valid reset to 0. col_addr, mode and iter_out reset to 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, SW_REQ, SW_WAIT, CHECK, TH_REQ, TH_WAIT, COLS, NEXT, FIN.
- IDLE:
  - start=1 moves to SW_REQ.
  - Same transition clears success, iteration counter, col_addr, and sets mode=BFITER.
- SW_REQ: sw_start=1 for exactly one cycle, then SW_WAIT.
- SW_WAIT: wait for sw_done=1 and latch sw_zero; next state CHECK.
- CHECK:
  - Latched zero=1: success<=1, go to FIN.
  - Else if iteration counter == NB_ITER: success<=0, go to FIN.
  - Else if mode==BFITER: go to TH_REQ.
  - Else go to COLS. BLACK and GRAY use a fixed threshold, so no th_start is issued.
- TH_REQ: th_start=1 for one cycle, then TH_WAIT. TH_WAIT: on th_done go to COLS.
- COLS:
  - col_valid=1 throughout.
  - On col_valid & col_ready: if col_addr==NUM_COLS-1, set col_addr<=0 and go to NEXT; else col_addr<=col_addr+1.
  - When col_ready=0, col_addr and col_valid hold.
  - col_valid drops in the cycle after the last accept.
- NEXT:
  - If iteration==0 and mode==BFITER: mode<=BLACK.
  - Else if iteration==0 and mode==BLACK: mode<=GRAY.
  - Otherwise: mode<=BFITER and the iteration counter increments.
  - In all cases go to SW_REQ. The final CHECK therefore always follows a fresh syndrome weight.
- FIN: done=1 for one cycle, then IDLE. busy=0 in IDLE and in FIN's successor cycle.
- Iteration counter saturates at NB_ITER and never wraps; iter_out equals the counter.
- Latency with zero-wait handshakes, iteration 0 BFITER pass: start to first col_valid = 6 cycles.
- Stray pulses are ignored in every state other than their wait state: sw_done outside SW_WAIT, th_done outside TH_WAIT, col_ready outside COLS.
- start while busy has no effect.

Decomposition:
- Package bike_dec_pkg holds:
  - the state enum;
  - mode encodings MODE_BFITER=2'd0, MODE_BLACK=2'd1, MODE_GRAY=2'd2;
  - width helper constants.
- One sub-module: bike_sat_counter (SIZE, MAX_VALUE; clk, resetn, clear, enable, cnt_out). It is an enable-driven increment counter that stops at MAX_VALUE. Used for the iteration count.
- The column-address counter stays inline.

Test Plan:
- Reset mid-COLS: assert resetn=0 with col_addr=17 -> next cycle state IDLE, col_valid=0, col_addr=0, busy=0, no done pulse.
- Never-zero syndrome, NB_ITER=5, NUM_COLS=48, all handshakes immediate -> exactly 7 column passes (mode sequence 0,1,2,0,0,0,0) and 5 th_start pulses. Expect 8 sw_start pulses, then done with success=0 and iter_out=5.
- sw_zero=1 at the first CHECK -> no th_start, no col_valid, done one cycle after CHECK, success=1, iter_out=0.
- sw_zero=1 after the GRAY pass of iteration 0 -> success=1, iter_out=1, and 3 passes observed.
- Random col_ready back-pressure (50%) -> every col_addr 0..47 accepted exactly once per pass, in order, and col_addr stable while col_ready=0.
- start pulsed during SW_WAIT, with spurious th_done/sw_done outside their wait states -> state sequence identical to the run without those pulses.

Source files
------------

// File: rtl/bike_bgf_iter_ctrl_pkg.sv
// Shared types and constants for the BIKE BGF decoder sequencing logic.
package bike_dec_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SW_REQ,
    S_SW_WAIT,
    S_CHECK,
    S_TH_REQ,
    S_TH_WAIT,
    S_COLS,
    S_NEXT,
    S_FIN
  } state_t;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_BFITER = 2'd0;
  localparam logic [MODE_W-1:0] MODE_BLACK  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_GRAY   = 2'd2;

  localparam int unsigned DEF_NB_ITER  = 5;
  localparam int unsigned DEF_NUM_COLS = 48;
  localparam int unsigned DEF_COL_W    = 6;
  localparam int unsigned DEF_ITER_W   = 3;

endpackage

// File: rtl/bike_bgf_iter_ctrl_sat_counter.sv
// Enable-driven increment counter that stops at MAX_VALUE instead of wrapping.
module bike_sat_counter #(
  parameter int unsigned SIZE      = 3,
  parameter int unsigned MAX_VALUE = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            enable,
  output logic [SIZE-1:0] cnt_out
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_out <= '0;
    end else if (clear) begin
      cnt_out <= '0;
    end else if (enable && (cnt_out != SIZE'(MAX_VALUE))) begin
      cnt_out <= cnt_out + SIZE'(1);
    end
  end

endmodule

// File: rtl/bike_bgf_iter_ctrl.sv
// BGF decoder sequencer: syndrome weight -> threshold -> column sweep, per pass,
// with BLACK/GRAY mask passes only in iteration 0.
module bike_bgf_iter_ctrl
  import bike_dec_pkg::*;
#(
  parameter int unsigned NB_ITER  = DEF_NB_ITER,
  parameter int unsigned NUM_COLS = DEF_NUM_COLS,
  parameter int unsigned COL_W    = DEF_COL_W,
  parameter int unsigned ITER_W   = DEF_ITER_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic              sw_start,
  input  logic              sw_done,
  input  logic              sw_zero,
  output logic              th_start,
  input  logic              th_done,
  output logic              col_valid,
  input  logic              col_ready,
  output logic [COL_W-1:0]  col_addr,
  output logic [MODE_W-1:0] mode,
  output logic [ITER_W-1:0] iter_out
);

  state_t state;
  logic   zero_q;
  logic   iter_clr;
  logic   iter_inc;
  logic   iter_first;

  assign iter_first = (iter_out == '0);
  assign iter_clr   = (state == S_IDLE) && start;
  // Iteration 0 walks BFITER -> BLACK -> GRAY before the counter advances.
  assign iter_inc   = (state == S_NEXT) &&
                      !(iter_first && ((mode == MODE_BFITER) || (mode == MODE_BLACK)));

  bike_sat_counter #(
    .SIZE      (ITER_W),
    .MAX_VALUE (NB_ITER)
  ) u_iter_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (iter_clr),
    .enable  (iter_inc),
    .cnt_out (iter_out)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      success   <= 1'b0;
      sw_start  <= 1'b0;
      th_start  <= 1'b0;
      col_valid <= 1'b0;
      col_addr  <= '0;
      mode      <= MODE_BFITER;
      zero_q    <= 1'b0;
    end else begin
      sw_start <= 1'b0;
      th_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SW_REQ;
            busy     <= 1'b1;
            success  <= 1'b0;
            col_addr <= '0;
            mode     <= MODE_BFITER;
            sw_start <= 1'b1;
          end
        end
        S_SW_REQ: state <= S_SW_WAIT;
        S_SW_WAIT: begin
          if (sw_done) begin
            zero_q <= sw_zero;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (zero_q) begin
            success <= 1'b1;
            done    <= 1'b1;
            state   <= S_FIN;
          end else if (iter_out == ITER_W'(NB_ITER)) begin
            success <= 1'b0;
            done    <= 1'b1;
            state   <= S_FIN;
          end else if (mode == MODE_BFITER) begin
            th_start <= 1'b1;
            state    <= S_TH_REQ;
          end else begin
            // Mask passes use a fixed threshold, so skip the threshold unit.
            col_valid <= 1'b1;
            state     <= S_COLS;
          end
        end
        S_TH_REQ: state <= S_TH_WAIT;
        S_TH_WAIT: begin
          if (th_done) begin
            col_valid <= 1'b1;
            state     <= S_COLS;
          end
        end
        S_COLS: begin
          if (col_ready) begin
            if (col_addr == COL_W'(NUM_COLS - 1)) begin
              col_addr  <= '0;
              col_valid <= 1'b0;
              state     <= S_NEXT;
            end else begin
              col_addr <= col_addr + COL_W'(1);
            end
          end
        end
        S_NEXT: begin
          if (iter_first && (mode == MODE_BFITER)) begin
            mode <= MODE_BLACK;
          end else if (iter_first && (mode == MODE_BLACK)) begin
            mode <= MODE_GRAY;
          end else begin
            mode <= MODE_BFITER;
          end
          sw_start <= 1'b1;
          state    <= S_SW_REQ;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bike_bgf_iter_ctrl.sv
// Self-checking bench for bike_bgf_iter_ctrl: vector table, random runs vs a pass-level model.
module tb_bike_bgf_iter_ctrl;

  localparam int unsigned NB_ITER  = 5;
  localparam int unsigned NUM_COLS = 48;
  localparam int unsigned COL_W    = 6;
  localparam int unsigned ITER_W   = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              busy;
  logic              done;
  logic              success;
  logic              sw_start;
  logic              sw_done;
  logic              sw_zero;
  logic              th_start;
  logic              th_done;
  logic              col_valid;
  logic              col_ready;
  logic [COL_W-1:0]  col_addr;
  logic [1:0]        mode;
  logic [ITER_W-1:0] iter_out;

  bike_bgf_iter_ctrl #(
    .NB_ITER  (NB_ITER),
    .NUM_COLS (NUM_COLS),
    .COL_W    (COL_W),
    .ITER_W   (ITER_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .success   (success),
    .sw_start  (sw_start),
    .sw_done   (sw_done),
    .sw_zero   (sw_zero),
    .th_start  (th_start),
    .th_done   (th_done),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_addr  (col_addr),
    .mode      (mode),
    .iter_out  (iter_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    zi;
    int    pct;
    bit    stray;
    bit    fast;
    int    passes;
    int    th;
    int    sw;
    bit    succ;
    int    iter;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int sw_cnt, th_cnt, n_sw, n_th, sw_idx, zero_idx, ready_pct, exp_addr;
  int addr_err, stable_err, mode_err;
  bit stray_on, fast_on;
  logic [1:0] pass_mode[$];
  logic       prev_valid, prev_ready;
  logic [COL_W-1:0] prev_addr;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Pass-level reference: walks checks in order; zi = index of the weight result that is zero.
  task automatic model(input int zi, output int passes, output int th, output int sw,
                       output bit succ, output int iter, output int modes[$]);
    int m;
    passes = 0; th = 0; sw = 0; succ = 0; iter = 0; m = 0;
    modes = {};
    for (int k = 0; k < 100; k++) begin
      sw++;
      if (k == zi) begin succ = 1; break; end
      if (iter == NB_ITER) break;
      if (m == 0) th++;
      passes++;
      modes.push_back(m);
      if (iter == 0 && m < 2) m++;
      else begin m = 0; iter++; end
    end
  endtask

  task automatic clear_run_state();
    sw_cnt = 0; th_cnt = 0; n_sw = 0; n_th = 0; sw_idx = 0; exp_addr = 0;
    addr_err = 0; stable_err = 0; mode_err = 0;
    pass_mode = {};
    prev_valid = 0; prev_ready = 0; prev_addr = '0;
  endtask

  // One cycle: sample outputs at negedge, then drive responder inputs for the next edge.
  task automatic tick();
    @(negedge clk);
    start = 1'b0;
    if (sw_start) n_sw++;
    if (th_start) n_th++;
    if (col_valid && prev_valid && !prev_ready && col_addr != prev_addr) stable_err++;
    sw_done = 1'b0;
    th_done = 1'b0;
    if (stray_on && sw_cnt > 1) start = 1'b1;
    if (sw_cnt > 0) begin
      sw_cnt--;
      if (sw_cnt == 0) begin
        sw_done = 1'b1;
        sw_zero = (sw_idx == zero_idx);
        sw_idx++;
      end
    end
    if (sw_start) sw_cnt = fast_on ? 1 : int'($urandom_range(1, 3));
    if (th_cnt > 0) begin
      th_cnt--;
      if (th_cnt == 0) th_done = 1'b1;
    end
    if (th_start) th_cnt = fast_on ? 1 : int'($urandom_range(1, 3));
    col_ready = (int'($urandom_range(0, 99)) < ready_pct);
    if (stray_on && col_valid) begin
      sw_done = 1'($urandom_range(0, 1));
      sw_zero = 1'($urandom_range(0, 1));
      th_done = 1'($urandom_range(0, 1));
    end
    if (col_valid && col_ready) begin
      if (int'(col_addr) != exp_addr) addr_err++;
      if (col_addr == '0) pass_mode.push_back(mode);
      if (pass_mode.size() > 0 && mode != pass_mode[$]) mode_err++;
      exp_addr = (int'(col_addr) == NUM_COLS - 1) ? 0 : int'(col_addr) + 1;
    end
    prev_valid = col_valid;
    prev_ready = col_ready;
    prev_addr  = col_addr;
  endtask

  task automatic run_check(input vec_t v);
    int  cyc, first_cv, done_cyc, busy_err, seq_err;
    bit  got, d_succ;
    int  d_iter;
    int  m_pass, m_th, m_sw, m_iter;
    bit  m_succ;
    int  m_modes[$];
    clear_run_state();
    zero_idx = v.zi; ready_pct = v.pct; stray_on = v.stray; fast_on = v.fast;
    @(negedge clk);
    start = 1'b1;
    cyc = 0; first_cv = -1; done_cyc = -1; busy_err = 0; got = 0; d_succ = 0; d_iter = -1;
    while (!got && cyc < 5000) begin
      tick();
      cyc++;
      if (col_valid && first_cv < 0) first_cv = cyc;
      if (!busy) busy_err++;
      if (done) begin
        got = 1; done_cyc = cyc; d_succ = success; d_iter = int'(iter_out);
      end
    end
    chk({v.nm, " done_seen"}, int'(got), 1);
    stray_on = 0;
    tick();
    chk({v.nm, " done_one_cycle"}, int'(done), 0);
    chk({v.nm, " busy_after"}, int'(busy), 0);
    chk({v.nm, " success_held"}, int'(success), int'(v.succ));
    chk({v.nm, " busy_during"}, busy_err, 0);
    chk({v.nm, " passes"}, pass_mode.size(), v.passes);
    chk({v.nm, " th_starts"}, n_th, v.th);
    chk({v.nm, " sw_starts"}, n_sw, v.sw);
    chk({v.nm, " success"}, int'(d_succ), int'(v.succ));
    chk({v.nm, " iter_out"}, d_iter, v.iter);
    chk({v.nm, " addr_order"}, addr_err, 0);
    chk({v.nm, " addr_stable"}, stable_err, 0);
    chk({v.nm, " mode_stable"}, mode_err, 0);
    model(v.zi, m_pass, m_th, m_sw, m_succ, m_iter, m_modes);
    seq_err = (m_modes.size() != pass_mode.size()) ? 1 : 0;
    for (int i = 0; i < m_modes.size() && i < pass_mode.size(); i++)
      if (int'(pass_mode[i]) != m_modes[i]) seq_err++;
    chk({v.nm, " mode_seq"}, seq_err, 0);
    if (v.fast) begin
      if (v.passes == 0) begin
        chk({v.nm, " no_col_valid"}, first_cv, -1);
        chk({v.nm, " done_latency"}, done_cyc, 4);
      end else begin
        chk({v.nm, " first_col_latency"}, first_cv, 6);
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    vec_t rv;
    int   rp, rt, rs, ri;
    bit   rsu;
    int   rm[$];
    int   guard;
    bit   saw_done;

    vecs.push_back('{"zero_first",      0, 100, 0, 1, 0, 0, 1, 1, 0});
    vecs.push_back('{"zero_after_bf",   1, 100, 0, 0, 1, 1, 2, 1, 0});
    vecs.push_back('{"zero_after_gray", 3, 100, 0, 1, 3, 1, 4, 1, 1});
    vecs.push_back('{"zero_iter3",      5,  70, 0, 0, 5, 3, 6, 1, 3});
    vecs.push_back('{"zero_last",       7, 100, 0, 0, 7, 5, 8, 1, 5});
    vecs.push_back('{"never_zero",     99, 100, 0, 1, 7, 5, 8, 0, 5});
    vecs.push_back('{"backpressure",   99,  50, 0, 0, 7, 5, 8, 0, 5});
    vecs.push_back('{"stray_pulses",    4,  60, 1, 0, 4, 2, 5, 1, 2});

    resetn = 1'b0; start = 1'b0; sw_done = 1'b0; sw_zero = 1'b0;
    th_done = 1'b0; col_ready = 1'b0;
    stray_on = 0; fast_on = 1; ready_pct = 100; zero_idx = 99;
    clear_run_state();
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset success", int'(success), 0);
    chk("reset strobes", int'({sw_start, th_start, col_valid}), 0);
    chk("reset col_addr", int'(col_addr), 0);
    chk("reset mode_iter", int'({mode, iter_out}), 0);
    resetn = 1'b1;

    foreach (vecs[i]) run_check(vecs[i]);

    for (int r = 0; r < 5; r++) begin
      rv.nm    = $sformatf("rand%0d", r);
      rv.zi    = int'($urandom_range(0, 9));
      rv.pct   = int'($urandom_range(30, 100));
      rv.stray = 1'($urandom_range(0, 1));
      rv.fast  = 0;
      model(rv.zi, rp, rt, rs, rsu, ri, rm);
      rv.passes = rp; rv.th = rt; rv.sw = rs; rv.succ = rsu; rv.iter = ri;
      run_check(rv);
    end

    // Reset while sweeping column 17 aborts with no done pulse.
    clear_run_state();
    zero_idx = 99; ready_pct = 100; stray_on = 0; fast_on = 1;
    @(negedge clk);
    start = 1'b1;
    guard = 0;
    while (!(col_valid && col_addr == COL_W'(17)) && guard < 500) begin
      tick();
      guard++;
    end
    chk("rst_mid reached col17", int'(guard < 500), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid col_valid", int'(col_valid), 0);
    chk("rst_mid col_addr", int'(col_addr), 0);
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid done", int'(done), 0);
    chk("rst_mid mode_iter", int'({mode, iter_out}), 0);
    resetn = 1'b1;
    clear_run_state();
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) saw_done = 1;
    end
    chk("rst_mid stays idle", int'(saw_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
